// File: rtl/elastic_pipe_register.sv
// elastic_pipe_register: STAGES-deep valid/ready register chain with bubble
// collapsing, back-pressure, flush and synchronous reset. Each beat leaves
// exactly once and in order, with full throughput and STAGES-cycle latency.
module elastic_pipe_register #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [WIDTH-1:0]                 in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [WIDTH-1:0]                 out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(STAGES+1)-1:0]      occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    // Stage 0 is the input side, stage STAGES-1 drives the outputs.
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] adv_c;
    logic [OCC_W-1:0]  occ_q;
    logic              push_c;

    // Number of set bits in a valid vector.
    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // Advance ripple: a stage may load if the stage after it moves or it is empty.
    always_comb begin
        logic a;
        adv_c = '0;
        a     = out_ready | ~v_q[STAGES-1];
        adv_c[STAGES-1] = a;
        for (int unsigned j = 1; j < STAGES; j++) begin
            a = a | ~v_q[STAGES-1-j];
            adv_c[STAGES-1-j] = a;
        end
    end

    // Upstream acceptance never depends on in_valid or in.
    assign in_ready = adv_c[0] & ~flush & ~rst;
    assign push_c   = in_valid & in_ready;

    // Next valid bits: reset and flush empty the chain, otherwise shift on advance.
    always_comb begin
        v_d = v_q;
        if (rst || flush) begin
            v_d = '0;
        end else begin
            if (adv_c[0]) begin
                v_d[0] = push_c;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv_c[k]) begin
                    v_d[k] = v_q[k-1];
                end
            end
        end
    end

    // Valid bits and occupancy view.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            v_q   <= v_d;
            occ_q <= popcount(v_d);
        end
    end

    // Data only moves when a real beat moves, so an empty output keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= RESET_VAL;
            end
        end else if (!flush) begin
            if (adv_c[0] && push_c) begin
                data_q[0] <= in;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv_c[k] && v_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out       = data_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
